// File: rtl/flex_fifo_wctrl_if.sv
// flex_fifo_wctrl_if: producer, memory write port and cross-domain pointer bundle for the write-side controller
interface flex_fifo_wctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wenable;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic                  clear_ovf;
  logic                  wclk_en;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  modport master (
    output wenable, wdata_in, rptr_gray, clear_ovf,
    input  wclk_en, waddr, wdata, wptr_gray, full, almost_full, count, overflow
  );
  modport slave (
    input  wenable, wdata_in, rptr_gray, clear_ovf,
    output wclk_en, waddr, wdata, wptr_gray, full, almost_full, count, overflow
  );
endinterface

// File: rtl/flex_fifo_wctrl.sv
// flex_fifo_wctrl: write-domain pointer, full/almost-full/occupancy and overflow logic of the dual-clock flex FIFO
module flex_fifo_wctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH-1
) (
  input logic wclk,
  input logic n_rst,
  flex_fifo_wctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] af_thresh = (ADDR_WIDTH+1)'(AFULL_THRESH);
  logic [ADDR_WIDTH:0] wbin, wbin_next, wgray_next, rq1, rq2, rbin;
  logic                full_next;
  assign bus.wclk_en  = bus.wenable & ~bus.full;
  assign bus.waddr    = wbin[ADDR_WIDTH-1:0];
  assign bus.wdata    = bus.wdata_in;
  assign wbin_next    = wbin + (ADDR_WIDTH+1)'(bus.wclk_en);
  assign wgray_next   = wbin_next ^ (wbin_next >> 1);
  // full when the next write pointer is a whole lap ahead of the synchronised read pointer
  assign full_next    = wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};
  genvar i;
  for (i = 0; i <= ADDR_WIDTH; i++) begin : g_rbin
    assign rbin[i] = ^(rq2 >> i);
  end
  assign bus.count       = wbin - rbin;
  assign bus.almost_full = bus.count >= af_thresh;
  always_ff @(posedge wclk or negedge n_rst) begin
    if (!n_rst) begin
      wbin          <= '0;
      bus.wptr_gray <= '0;
      rq1           <= '0;
      rq2           <= '0;
      bus.full      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      rq1           <= bus.rptr_gray;
      rq2           <= rq1;
      wbin          <= wbin_next;
      bus.wptr_gray <= wgray_next;
      bus.full      <= full_next;
      bus.overflow  <= (bus.wenable & bus.full) ? 1'b1 : bus.clear_ovf ? 1'b0 : bus.overflow;
    end
  end
endmodule

// File: tb/tb_flex_fifo_wctrl.sv
// tb_flex_fifo_wctrl: directed scoreboard bench for the flex FIFO write controller (depth 4)
module tb_flex_fifo_wctrl;
  logic wclk = 1'b0;
  logic n_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;
  flex_fifo_wctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();
  flex_fifo_wctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3)) dut (
    .wclk (wclk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );
  always #5 wclk = ~wclk;
  typedef struct {
    string      name;
    logic       en;
    logic [1:0] addr;
    logic [2:0] gray;
    logic       full;
    logic       af;
    logic [2:0] cnt;
    logic       ovf;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];
  exp_t m;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  always @(negedge wclk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      chk(m.name,
          32'({bus.wclk_en, bus.waddr, bus.wptr_gray, bus.full, bus.almost_full, bus.count, bus.overflow, bus.wdata}),
          32'({m.en, m.addr, m.gray, m.full, m.af, m.cnt, m.ovf, m.data}));
    end
  end
  initial begin
    #20000;
    if (!done) begin
      chk("timeout", 32'd1, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  task automatic drive(input string nm, input logic we, input logic [2:0] rg, input logic clr,
                       input logic en, input logic [1:0] ad, input logic [2:0] gy, input logic fu,
                       input logic af, input logic [2:0] cn, input logic ov);
    exp_t e;
    logic [7:0] d;
    #1;
    d = 8'($urandom);
    bus.wenable   = we;
    bus.rptr_gray = rg;
    bus.clear_ovf = clr;
    bus.wdata_in  = d;
    e = '{nm, en, ad, gy, fu, af, cn, ov, d};
    q.push_back(e);
  endtask
  task automatic step(input string nm, input logic we, input logic [2:0] rg, input logic clr,
                      input logic en, input logic [1:0] ad, input logic [2:0] gy, input logic fu,
                      input logic af, input logic [2:0] cn, input logic ov);
    drive(nm, we, rg, clr, en, ad, gy, fu, af, cn, ov);
    @(posedge wclk);
  endtask
  task automatic rst_pulse(input string nm, input logic [2:0] rg);
    drive(nm, 1'b0, rg, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0);
    #1 n_rst = 1'b0;
    #1 chk({nm, "_async"},
           32'({bus.wclk_en, bus.waddr, bus.wptr_gray, bus.full, bus.almost_full, bus.count, bus.overflow}),
           32'd0);
    @(negedge wclk);
    #2 n_rst = 1'b1;
    @(posedge wclk);
  endtask
  initial begin
    bus.wenable = 1'b0; bus.rptr_gray = '0; bus.clear_ovf = 1'b0; bus.wdata_in = '0;
    @(posedge wclk);
    rst_pulse("reset_state", 3'b000);
    step("mid_w0",      1, 3'b000, 0,   1, 0, 3'b000, 0, 0, 0, 0);
    step("mid_w1",      1, 3'b000, 0,   1, 1, 3'b001, 0, 0, 1, 0);
    rst_pulse("reset_mid", 3'b000);
    step("fill0",       1, 3'b000, 0,   1, 0, 3'b000, 0, 0, 0, 0);
    step("fill1",       1, 3'b000, 0,   1, 1, 3'b001, 0, 0, 1, 0);
    step("fill2",       1, 3'b000, 0,   1, 2, 3'b011, 0, 0, 2, 0);
    step("fill3",       1, 3'b000, 0,   1, 3, 3'b010, 0, 1, 3, 0);
    step("fill_ovf",    1, 3'b000, 0,   0, 0, 3'b110, 1, 1, 4, 0);
    step("ovf_set",     0, 3'b000, 0,   0, 0, 3'b110, 1, 1, 4, 1);
    step("ovf_setwins", 1, 3'b000, 1,   0, 0, 3'b110, 1, 1, 4, 1);
    step("ovf_clr",     0, 3'b000, 1,   0, 0, 3'b110, 1, 1, 4, 1);
    step("ovf_cleared", 0, 3'b000, 0,   0, 0, 3'b110, 1, 1, 4, 0);
    step("rel1",        0, 3'b001, 0,   0, 0, 3'b110, 1, 1, 4, 0);
    step("rel2",        0, 3'b001, 0,   0, 0, 3'b110, 1, 1, 4, 0);
    step("rel3_cnt",    0, 3'b001, 0,   0, 0, 3'b110, 1, 1, 3, 0);
    step("rel4_wr",     1, 3'b001, 0,   1, 0, 3'b110, 0, 1, 3, 0);
    step("rel5_full",   0, 3'b001, 0,   0, 1, 3'b111, 1, 1, 4, 0);
    rst_pulse("reset_wrap", 3'b000);
    step("wrap01", 1, 3'b000, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    step("wrap02", 0, 3'b000, 0, 0, 1, 3'b001, 0, 0, 1, 0);
    step("wrap03", 1, 3'b000, 0, 1, 1, 3'b001, 0, 0, 1, 0);
    step("wrap04", 0, 3'b001, 0, 0, 2, 3'b011, 0, 0, 2, 0);
    step("wrap05", 1, 3'b001, 0, 1, 2, 3'b011, 0, 0, 2, 0);
    step("wrap06", 0, 3'b011, 0, 0, 3, 3'b010, 0, 0, 2, 0);
    step("wrap07", 1, 3'b011, 0, 1, 3, 3'b010, 0, 0, 2, 0);
    step("wrap08", 0, 3'b010, 0, 0, 0, 3'b110, 0, 0, 2, 0);
    step("wrap09", 1, 3'b010, 0, 1, 0, 3'b110, 0, 0, 2, 0);
    step("wrap10", 0, 3'b110, 0, 0, 1, 3'b111, 0, 0, 2, 0);
    step("wrap11", 1, 3'b110, 0, 1, 1, 3'b111, 0, 0, 2, 0);
    step("wrap12", 0, 3'b111, 0, 0, 2, 3'b101, 0, 0, 2, 0);
    step("wrap13", 1, 3'b111, 0, 1, 2, 3'b101, 0, 0, 2, 0);
    step("wrap14", 0, 3'b101, 0, 0, 3, 3'b100, 0, 0, 2, 0);
    step("wrap15", 1, 3'b101, 0, 1, 3, 3'b100, 0, 0, 2, 0);
    step("wrap16", 0, 3'b100, 0, 0, 0, 3'b000, 0, 0, 2, 0);
    step("wrap17", 0, 3'b100, 0, 0, 0, 3'b000, 0, 0, 2, 0);
    step("wrap18", 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 0);
    step("wrap19", 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 1, 0);
    step("wrap20", 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    step("af_w0",  1, 3'b000, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    step("af_w1",  1, 3'b000, 0, 1, 1, 3'b001, 0, 0, 1, 0);
    step("af_w2",  1, 3'b000, 0, 1, 2, 3'b011, 0, 0, 2, 0);
    step("af_on",  0, 3'b000, 0, 0, 3, 3'b010, 0, 1, 3, 0);
    step("af_rd0", 0, 3'b001, 0, 0, 3, 3'b010, 0, 1, 3, 0);
    step("af_rd1", 0, 3'b001, 0, 0, 3, 3'b010, 0, 1, 3, 0);
    step("af_off", 0, 3'b001, 0, 0, 3, 3'b010, 0, 0, 2, 0);
    repeat (2) @(posedge wclk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
